// File: rtl/imem_pkg.sv
// Constants and FSM encoding shared by the PC, instruction-memory and decode stages.
package imem_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 32;
  localparam logic [DATA_W-1:0] NOP_WORD = 16'h0;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/imem_fetch_responder_if.sv
// Fetch request, instruction response and program-load bundle between PC, imem and decode.
interface imem_fetch_responder_if #(
  parameter int ADDR_W = imem_pkg::ADDR_W,
  parameter int DATA_W = imem_pkg::DATA_W
) ();

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // Once raised, valid and its payload stay stable until that transfer; ready may
  // depend combinationally on the other side's ready but never on its own valid.
  logic              fetch_valid;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;

  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_addr;
  logic              instr_err;
  logic              instr_ready;

  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;

  modport responder (
    input  fetch_valid, fetch_addr, instr_ready, load_en, load_addr, load_data,
    output fetch_ready, instr_valid, instr, instr_addr, instr_err
  );

  modport requester (
    output fetch_valid, fetch_addr, instr_ready, load_en, load_addr, load_data,
    input  fetch_ready, instr_valid, instr, instr_addr, instr_err
  );

endinterface

// File: rtl/imem_array.sv
// DEPTH x DATA_W program storage: one write port, one combinational read port,
// write-first bypass. Out-of-range writes are dropped; out-of-range reads return 0.
module imem_array #(
  parameter int ADDR_W = imem_pkg::ADDR_W,
  parameter int DATA_W = imem_pkg::DATA_W,
  parameter int DEPTH  = imem_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;
  logic              rd_ok;

  assign wr_ok = we && ({1'b0, waddr} < DEPTH_L);
  assign rd_ok = {1'b0, raddr} < DEPTH_L;

  // Contents are deliberately not reset so a loaded program survives rst_n.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[waddr[IDX_W-1:0]] <= wdata;
  end

  always_comb begin
    rdata = '0;
    if (wr_ok && (waddr == raddr)) rdata = wdata;
    else if (rd_ok)                rdata = mem[raddr[IDX_W-1:0]];
  end

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: one-entry registered response stage in front of imem_array,
// answering PC fetches one cycle later and holding each word until decode accepts it.
module imem_fetch_responder #(
  parameter int ADDR_W = imem_pkg::ADDR_W,
  parameter int DATA_W = imem_pkg::DATA_W,
  parameter int DEPTH  = imem_pkg::DEPTH,
  parameter logic [DATA_W-1:0] NOP_WORD = imem_pkg::NOP_WORD
) (
  input  logic                     clk,
  input  logic                     rst_n,
  imem_fetch_responder_if.responder bus,
  output imem_pkg::state_t         state
);

  import imem_pkg::*;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic              valid_q;
  logic [DATA_W-1:0] instr_q;
  logic [ADDR_W-1:0] addr_q;
  logic              err_q;

  logic              accept;
  logic              fetch_in_range;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] next_instr;

  imem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (bus.load_en),
    .waddr (bus.load_addr),
    .wdata (bus.load_data),
    .raddr (bus.fetch_addr),
    .rdata (rd_data)
  );

  // No bubble: a held response that leaves this cycle frees the slot for the next fetch.
  assign bus.fetch_ready = !valid_q || bus.instr_ready;
  assign accept          = bus.fetch_valid && bus.fetch_ready;
  assign fetch_in_range  = {1'b0, bus.fetch_addr} < DEPTH_L;
  assign next_instr      = fetch_in_range ? rd_data : NOP_WORD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      valid_q <= 1'b0;
      instr_q <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      // The response register only changes on accept, so a held word ignores later loads.
      if (accept) begin
        instr_q <= next_instr;
        addr_q  <= bus.fetch_addr;
        err_q   <= !fetch_in_range;
      end
      case (state)
        EMPTY: begin
          if (accept) begin
            state   <= FULL;
            valid_q <= 1'b1;
          end
        end
        FULL: begin
          if (bus.instr_ready && !accept) begin
            state   <= EMPTY;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state   <= EMPTY;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_addr  = addr_q;
  assign bus.instr_err   = err_q;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench for imem_fetch_responder: directed vector table, reset and range corner cases,
// and a randomized run against a queue-based reference model.
module tb_imem_fetch_responder;

  import imem_pkg::*;

  localparam int AW = 5;
  localparam int DW = 16;
  localparam int RW = AW + DW + 1;

  logic clk;
  logic rst_n;
  state_t state32;
  state_t state24;

  int n_checks = 0;
  int n_fail   = 0;

  imem_fetch_responder_if #(.ADDR_W(AW), .DATA_W(DW)) f32 ();
  imem_fetch_responder_if #(.ADDR_W(AW), .DATA_W(DW)) f24 ();

  imem_fetch_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(32), .NOP_WORD(16'h0)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (f32),
    .state (state32)
  );

  imem_fetch_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(24), .NOP_WORD(16'h0)) dut24 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (f24),
    .state (state24)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic fv, input logic [AW-1:0] fa, input logic ir,
                         input logic le, input logic [AW-1:0] la, input logic [DW-1:0] ld);
    f32.fetch_valid = fv;
    f32.fetch_addr  = fa;
    f32.instr_ready = ir;
    f32.load_en     = le;
    f32.load_addr   = la;
    f32.load_data   = ld;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          fv;
    logic [AW-1:0] fa;
    logic          ir;
    logic          le;
    logic [AW-1:0] la;
    logic [DW-1:0] ld;
    logic          exp_rdy;
    logic          exp_v;
    logic [DW-1:0] exp_i;
    logic [AW-1:0] exp_a;
    logic          exp_e;
  } vec_t;

  vec_t vt[$];

  task automatic add_vec(input logic fv, input logic [AW-1:0] fa, input logic ir,
                         input logic le, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                         input logic rdy, input logic v, input logic [DW-1:0] i,
                         input logic [AW-1:0] a, input logic e);
    vec_t t;
    t.fv = fv; t.fa = fa; t.ir = ir; t.le = le; t.la = la; t.ld = ld;
    t.exp_rdy = rdy; t.exp_v = v; t.exp_i = i; t.exp_a = a; t.exp_e = e;
    vt.push_back(t);
  endtask

  // ---------------- scoreboard state ----------------
  logic [RW-1:0] exp_q[$];
  logic [DW-1:0] model32 [32];
  logic [DW-1:0] model24 [24];

  initial begin
    logic [RW-1:0] exp_w;
    logic [DW-1:0] word;
    logic          rdy_m;

    rst_n = 1'b0;
    drive32(1'b0, '0, 1'b1, 1'b0, '0, '0);
    f24.fetch_valid = 1'b0; f24.fetch_addr = '0; f24.instr_ready = 1'b1;
    f24.load_en = 1'b0; f24.load_addr = '0; f24.load_data = '0;
    repeat (3) step();

    check("rst_valid", 32'(f32.instr_valid), 32'd0);
    check("rst_instr", 32'(f32.instr), 32'd0);
    check("rst_addr",  32'(f32.instr_addr), 32'd0);
    check("rst_err",   32'(f32.instr_err), 32'd0);
    check("rst_state", 32'(state32), 32'(EMPTY));
    rst_n = 1'b1;
    step();
    check("rst_ready", 32'(f32.fetch_ready), 32'd1);

    // load 0..3, back-to-back fetch, stall hold, write-first collision, held-word load, PC wrap
    add_vec(0, 0, 1, 1, 0, 16'h1111, 1, 0, 16'h0,    0, 0);
    add_vec(0, 0, 1, 1, 1, 16'h2222, 1, 0, 16'h0,    0, 0);
    add_vec(0, 0, 1, 1, 2, 16'h3333, 1, 0, 16'h0,    0, 0);
    add_vec(0, 0, 1, 1, 3, 16'h4444, 1, 0, 16'h0,    0, 0);
    add_vec(1, 0, 1, 0, 0, 16'h0,    1, 1, 16'h1111, 0, 0);
    add_vec(1, 1, 1, 0, 0, 16'h0,    1, 1, 16'h2222, 1, 0);
    add_vec(1, 2, 1, 0, 0, 16'h0,    1, 1, 16'h3333, 2, 0);
    add_vec(1, 3, 1, 0, 0, 16'h0,    1, 1, 16'h4444, 3, 0);
    add_vec(1, 2, 1, 0, 0, 16'h0,    1, 1, 16'h3333, 2, 0);
    add_vec(1, 3, 0, 0, 0, 16'h0,    0, 1, 16'h3333, 2, 0);
    add_vec(1, 3, 0, 0, 0, 16'h0,    0, 1, 16'h3333, 2, 0);
    add_vec(1, 3, 0, 0, 0, 16'h0,    0, 1, 16'h3333, 2, 0);
    add_vec(1, 3, 1, 0, 0, 16'h0,    1, 1, 16'h4444, 3, 0);
    add_vec(1, 5, 1, 1, 5, 16'hABCD, 1, 1, 16'hABCD, 5, 0);
    add_vec(0, 0, 0, 1, 5, 16'h0F0F, 0, 1, 16'hABCD, 5, 0);
    add_vec(0, 0, 1, 0, 0, 16'h0,    1, 0, 16'h0,    0, 0);
    add_vec(1, 5, 1, 0, 0, 16'h0,    1, 1, 16'h0F0F, 5, 0);
    add_vec(1, 31, 1, 1, 31, 16'h7777, 1, 1, 16'h7777, 31, 0);
    add_vec(1, 0, 1, 0, 0, 16'h0,    1, 1, 16'h1111, 0, 0);
    add_vec(0, 0, 1, 0, 0, 16'h0,    1, 0, 16'h0,    0, 0);

    foreach (vt[k]) begin
      drive32(vt[k].fv, vt[k].fa, vt[k].ir, vt[k].le, vt[k].la, vt[k].ld);
      #1;
      check($sformatf("vec%0d_ready", k), 32'(f32.fetch_ready), 32'(vt[k].exp_rdy));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_valid", k), 32'(f32.instr_valid), 32'(vt[k].exp_v));
      check($sformatf("vec%0d_state", k), 32'(state32), 32'(vt[k].exp_v));
      if (vt[k].exp_v) begin
        check($sformatf("vec%0d_instr", k), 32'(f32.instr), 32'(vt[k].exp_i));
        check($sformatf("vec%0d_addr", k),  32'(f32.instr_addr), 32'(vt[k].exp_a));
        check($sformatf("vec%0d_err", k),   32'(f32.instr_err), 32'(vt[k].exp_e));
      end
    end

    // asynchronous reset while a response is held
    drive32(1'b1, 5'd1, 1'b0, 1'b0, '0, '0);
    step();
    check("ar_held_valid", 32'(f32.instr_valid), 32'd1);
    check("ar_held_instr", 32'(f32.instr), 32'h2222);
    drive32(1'b0, '0, 1'b0, 1'b0, '0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(f32.instr_valid), 32'd0);
    check("ar_instr", 32'(f32.instr), 32'd0);
    check("ar_addr",  32'(f32.instr_addr), 32'd0);
    check("ar_err",   32'(f32.instr_err), 32'd0);
    check("ar_state", 32'(state32), 32'(EMPTY));
    #2;
    rst_n = 1'b1;
    step();
    check("ar_no_replay", 32'(f32.instr_valid), 32'd0);
    drive32(1'b1, 5'd1, 1'b1, 1'b0, '0, '0);
    step();
    check("ar_retain_valid", 32'(f32.instr_valid), 32'd1);
    check("ar_retain_instr", 32'(f32.instr), 32'h2222);
    check("ar_retain_addr",  32'(f32.instr_addr), 32'd1);
    drive32(1'b0, '0, 1'b1, 1'b0, '0, '0);
    step();

    // DEPTH=24 instance: out-of-range fetch and dropped load
    for (int i = 0; i < 24; i++) begin
      word = 16'($urandom);
      model24[i] = word;
      f24.load_en = 1'b1; f24.load_addr = 5'(i); f24.load_data = word;
      step();
    end
    f24.load_en = 1'b1; f24.load_addr = 5'd30; f24.load_data = 16'hDEAD;
    f24.fetch_valid = 1'b1; f24.fetch_addr = 5'd30;
    step();
    check("oor_valid", 32'(f24.instr_valid), 32'd1);
    check("oor_instr", 32'(f24.instr), 32'h0);
    check("oor_err",   32'(f24.instr_err), 32'd1);
    check("oor_addr",  32'(f24.instr_addr), 32'd30);
    f24.load_en = 1'b0;
    f24.fetch_addr = 5'd24;
    step();
    check("oor24_instr", 32'(f24.instr), 32'h0);
    check("oor24_err",   32'(f24.instr_err), 32'd1);
    for (int i = 0; i < 24; i++) begin
      f24.fetch_addr = 5'(i);
      step();
      check($sformatf("d24_instr%0d", i), 32'(f24.instr), 32'(model24[i]));
      check($sformatf("d24_err%0d", i),   32'(f24.instr_err), 32'd0);
      check($sformatf("d24_addr%0d", i),  32'(f24.instr_addr), 32'(i));
    end
    f24.fetch_valid = 1'b0;
    step();

    // randomized traffic against a one-entry response queue model
    for (int i = 0; i < 32; i++) begin
      word = 16'($urandom);
      model32[i] = word;
      drive32(1'b0, '0, 1'b1, 1'b1, 5'(i), word);
      step();
    end
    drive32(1'b0, '0, 1'b1, 1'b0, '0, '0);
    step();
    exp_q.delete();
    for (int c = 0; c < 10000; c++) begin
      drive32(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
              5'($urandom_range(0, 31)), 16'($urandom));
      #1;
      rdy_m = (exp_q.size() == 0) || f32.instr_ready;
      check("rnd_ready", 32'(f32.fetch_ready), 32'(rdy_m));
      check("rnd_valid", 32'(f32.instr_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0 && f32.instr_ready) begin
        exp_w = exp_q.pop_front();
        check("rnd_resp", 32'({f32.instr_addr, f32.instr, f32.instr_err}), 32'(exp_w));
      end
      if (f32.fetch_valid && rdy_m) begin
        word = (f32.load_en && f32.load_addr == f32.fetch_addr) ? f32.load_data
                                                                 : model32[f32.fetch_addr];
        exp_q.push_back({f32.fetch_addr, word, 1'b0});
      end
      if (f32.load_en) model32[f32.load_addr] = f32.load_data;
      step();
    end
    drive32(1'b0, '0, 1'b1, 1'b0, '0, '0);
    #1;
    if (exp_q.size() != 0) begin
      exp_w = exp_q.pop_front();
      check("rnd_last_valid", 32'(f32.instr_valid), 32'd1);
      check("rnd_last_resp", 32'({f32.instr_addr, f32.instr, f32.instr_err}), 32'(exp_w));
    end
    step();
    check("rnd_drained", 32'(f32.instr_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
